relational_cmp_arbiter: RTL and testbench

//   Shares one unsigned relational comparator (lt/le/gt/eq) between NREQ

---
 rtl/relational_pkg.sv | 20 ++
 rtl/relational_cmp.sv | 20 ++
 rtl/relational_cmp_arbiter.sv | 112 +++++++++++
 tb/tb_relational_cmp_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relational_pkg.sv
// rtl/relational_pkg.sv - shared types and defaults for the relational compare arbiter
package relational_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic lt;
        logic le;
        logic gt;
        logic eq;
    } cmp_res_t;

endpackage

// File: rtl/relational_cmp.sv
// rtl/relational_cmp.sv - combinational unsigned comparator producing lt/le/gt/eq
module relational_cmp
    import relational_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_t         res
);

    // le and gt derive from lt/eq so the four flags can never disagree.
    always_comb begin
        res.lt = (a < b);
        res.eq = (a == b);
        res.le = res.lt | res.eq;
        res.gt = ~res.le;
    end

endmodule

// File: rtl/relational_cmp_arbiter.sv
// rtl/relational_cmp_arbiter.sv - round-robin sharing of one comparator between requesters
module relational_cmp_arbiter
    import relational_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic                    rsp_lt,
    output logic                    rsp_le,
    output logic                    rsp_gt,
    output logic                    rsp_eq,
    output logic                    busy,
    output logic [7:0]              cmp_cnt
);

    state_t            state;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    id_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [IDW-1:0]    grant_id;
    logic              grant_found;
    logic [2*NREQ-1:0] valid_dbl;
    logic [NREQ-1:0]   valid_rot;
    cmp_res_t          res;

    // Rotate so bit 0 is the requester at rr_ptr; lowest set bit wins.
    always_comb begin
        valid_dbl   = {req_valid, req_valid};
        valid_rot   = NREQ'(valid_dbl >> rr_ptr);
        grant_found = |valid_rot;
        grant_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                grant_id = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    relational_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a   (a_q),
        .b   (b_q),
        .res (res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_lt    <= 1'b0;
            rsp_le    <= 1'b0;
            rsp_gt    <= 1'b0;
            rsp_eq    <= 1'b0;
            cmp_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        a_q   <= req_a[grant_id*WIDTH +: WIDTH];
                        b_q   <= req_b[grant_id*WIDTH +: WIDTH];
                        id_q  <= grant_id;
                        state <= CMP;
                    end
                end
                CMP: begin
                    rsp_id    <= id_q;
                    rsp_lt    <= res.lt;
                    rsp_le    <= res.le;
                    rsp_gt    <= res.gt;
                    rsp_eq    <= res.eq;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmp_cnt   <= cmp_cnt + 8'd1;
                        // The requester just served drops to lowest priority.
                        rr_ptr    <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_relational_cmp_arbiter.sv
// tb/tb_relational_cmp_arbiter.sv - scoreboard bench for the relational compare arbiter
module tb_relational_cmp_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 3;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_lt, rsp_le, rsp_gt, rsp_eq;
    logic                  busy;
    logic [7:0]            cmp_cnt;

    relational_cmp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_lt    (rsp_lt),
        .rsp_le    (rsp_le),
        .rsp_gt    (rsp_gt),
        .rsp_eq    (rsp_eq),
        .busy      (busy),
        .cmp_cnt   (cmp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit lt;
        bit le;
        bit gt;
        bit eq;
    } exp_t;

    exp_t            sb[$];
    int              grant_log[$];
    exp_t            last_rsp;
    int              n_cmp = 0;
    int              n_fail = 0;
    int              model_ptr = 0;
    int              model_cnt = 0;
    int              lat = 0;
    int              n_rsp = 0;
    bit              outstanding = 0;
    bit              rsp_seen = 0;
    logic [IDW+3:0]  snap;
    logic [NREQ-1:0] last_grant = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a reference model of grants, results, latency and counter.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ready;
        exp_t e;
        exp_t p;
        int gid;
        int a;
        int b;
        if (!rst_n) begin
            chk("reset_req_ready", req_ready, 0);
            chk("reset_rsp_valid", rsp_valid, 0);
            chk("reset_cmp_cnt", cmp_cnt, 0);
            chk("reset_busy", busy, 0);
            sb.delete();
            outstanding = 0;
            rsp_seen = 0;
            model_ptr = 0;
            model_cnt = 0;
            last_grant = '0;
        end else begin
            lat++;
            exp_ready = '0;
            if (!outstanding) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (exp_ready == 0 && req_valid[(model_ptr + k) % NREQ])
                        exp_ready[(model_ptr + k) % NREQ] = 1'b1;
                end
            end
            chk("grant", req_ready, exp_ready);
            chk("cmp_cnt", cmp_cnt, model_cnt % 256);
            chk("busy", busy, outstanding);
            if (rsp_valid) begin
                if (!rsp_seen) begin
                    chk("latency", lat, 2);
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", sb.size(), 1);
                    end else begin
                        e = sb[0];
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_lt", rsp_lt, e.lt);
                        chk("rsp_le", rsp_le, e.le);
                        chk("rsp_gt", rsp_gt, e.gt);
                        chk("rsp_eq", rsp_eq, e.eq);
                    end
                    snap = {rsp_id, rsp_lt, rsp_le, rsp_gt, rsp_eq};
                    rsp_seen = 1;
                end else begin
                    chk("rsp_stable", {rsp_id, rsp_lt, rsp_le, rsp_gt, rsp_eq}, snap);
                end
                if (rsp_ready) begin
                    last_rsp = '{int'(rsp_id), rsp_lt, rsp_le, rsp_gt, rsp_eq};
                    if (sb.size() > 0) begin
                        p = sb.pop_front();
                        model_ptr = (p.id + 1) % NREQ;
                    end
                    n_rsp++;
                    model_cnt++;
                    outstanding = 0;
                    rsp_seen = 0;
                end
            end else if (outstanding && lat >= 2) begin
                chk("rsp_missing", rsp_valid, 1);
            end
            last_grant = req_ready;
            if (req_ready != 0 && !outstanding) begin
                gid = 0;
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) gid = k;
                a = int'(req_a[gid*WIDTH +: WIDTH]);
                b = int'(req_b[gid*WIDTH +: WIDTH]);
                e = '{gid, a < b, a <= b, a > b, a == b};
                sb.push_back(e);
                grant_log.push_back(gid);
                outstanding = 1;
                lat = 0;
            end
        end
    end

    task automatic wait_grant(input int i);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk); #1;
            if (last_grant[i]) break;
        end
        chk("grant_timeout", last_grant[i], 1);
    endtask

    task automatic wait_rsp_valid();
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (rsp_valid) break;
        end
        chk("rsp_valid_timeout", rsp_valid, 1);
    endtask

    task automatic issue(input int i, input int a, input int b);
        int n0;
        int t;
        n0 = n_rsp;
        @(posedge clk); #1;
        req_valid[i] = 1'b1;
        req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
        wait_grant(i);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        for (t = 0; t < 40; t++) begin
            if (n_rsp > n0) break;
            @(posedge clk); #1;
        end
        chk("rsp_timeout", int'(n_rsp > n0), 1);
    endtask

    task automatic run_random(input int req_prob, input int drop_prob, input bit rsp_rand, input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (last_grant[i] || !req_valid[i]) begin
                    if ($urandom_range(99) < req_prob) begin
                        req_valid[i] = 1'b1;
                        req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                        req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(99) < drop_prob) begin
                    req_valid[i] = 1'b0;
                end
            end
            if (rsp_rand) rsp_ready = 1'($urandom_range(1));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt0;
        req_valid = 4'b1111;
        req_a = NREQ*WIDTH'($urandom);
        req_b = NREQ*WIDTH'($urandom);
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;

        rsp_ready = 1'b1;
        issue(2, 3, 5);
        chk("single_id", last_rsp.id, 2);
        chk("single_lt", last_rsp.lt, 1);
        chk("single_le", last_rsp.le, 1);
        chk("single_gt", last_rsp.gt, 0);
        chk("single_eq", last_rsp.eq, 0);

        issue(0, 7, 7);
        chk("eq77_eq", last_rsp.eq, 1);
        chk("eq77_le", last_rsp.le, 1);
        chk("eq77_lt", last_rsp.lt, 0);
        chk("eq77_gt", last_rsp.gt, 0);
        issue(1, 7, 0);
        chk("gt70_gt", last_rsp.gt, 1);
        chk("gt70_le", last_rsp.le, 0);
        issue(3, 0, 7);
        chk("lt07_lt", last_rsp.lt, 1);
        chk("lt07_eq", last_rsp.eq, 0);

        do_reset();
        grant_log.delete();
        rsp_ready = 1'b1;
        run_random(100, 0, 1'b0, 24);
        chk("rr_count", int'(grant_log.size() >= 5), 1);
        if (grant_log.size() >= 5) begin
            chk("rr_0", grant_log[0], 0);
            chk("rr_1", grant_log[1], 1);
            chk("rr_2", grant_log[2], 2);
            chk("rr_3", grant_log[3], 3);
            chk("rr_4", grant_log[4], 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;

        rsp_ready = 1'b0;
        req_valid[1] = 1'b1;
        req_a[1*WIDTH +: WIDTH] = 3'd4;
        req_b[1*WIDTH +: WIDTH] = 3'd2;
        wait_grant(1);
        @(posedge clk); #1;
        req_valid = 4'b1111;
        wait_rsp_valid();
        cnt0 = int'(cmp_cnt);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_ready", req_ready, 0);
            chk("bp_cnt", cmp_cnt, cnt0);
            chk("bp_gt", rsp_gt, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_inc", cmp_cnt, (cnt0 + 1) % 256);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;

        rsp_ready = 1'b0;
        req_valid[3] = 1'b1;
        wait_grant(3);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        wait_rsp_valid();
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_cnt", cmp_cnt, 0);
        req_valid = 4'b1010;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        grant_log.delete();
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            if (grant_log.size() > 0) break;
        end
        chk("mid_grant_seen", grant_log.size(), 1);
        if (grant_log.size() > 0) chk("mid_first_grant", grant_log[0], 1);

        run_random(40, 5, 1'b1, 2500);
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
